// File: rtl/opb_master_pkg.sv
// Shared types and constants for the OPB master sequencer.
package opb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam int DEF_AWIDTH = 32;
    localparam int DEF_DWIDTH = 32;

    localparam logic [0:3] BE_ALL = 4'b1111;

endpackage

// File: rtl/opb_master_sequencer_if.sv
// User command/response and OPB master bus signals of the sequencer.
// The master modport is the sequencer side; slave is the fabric user plus
// the bus (arbiter and addressed slave) seen from the other end.
interface opb_master_sequencer_if
    import opb_master_pkg::*;
#(
    parameter int C_OPB_AWIDTH = DEF_AWIDTH,
    parameter int C_OPB_DWIDTH = DEF_DWIDTH
);

    // user command channel
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rnw;
    logic [0:C_OPB_AWIDTH-1] cmd_addr;
    logic [0:C_OPB_DWIDTH-1] cmd_wdata;
    logic [0:3]              cmd_be;

    // user response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [0:C_OPB_DWIDTH-1] rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    // OPB master side
    logic                    M_request;
    logic                    OPB_MGrant;
    logic                    M_select;
    logic [0:C_OPB_AWIDTH-1] M_ABus;
    logic [0:3]              M_BE;
    logic [0:C_OPB_DWIDTH-1] M_DBus;
    logic                    M_RNW;
    logic                    M_seqAddr;
    logic [0:C_OPB_DWIDTH-1] OPB_DBus;
    logic                    OPB_xferAck;
    logic                    OPB_errAck;
    logic                    OPB_retry;
    logic                    OPB_toutSup;

    modport master (
        input  cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        input  OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr
    );

    modport slave (
        output cmd_valid, cmd_rnw, cmd_addr, cmd_wdata, cmd_be, rsp_ready,
        output OPB_MGrant, OPB_DBus, OPB_xferAck, OPB_errAck, OPB_retry, OPB_toutSup,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  M_request, M_select, M_ABus, M_BE, M_DBus, M_RNW, M_seqAddr
    );

endinterface

// File: rtl/opb_master_timeout.sv
// XFER watchdog: counts unsuppressed cycles while enabled and flags the
// cycle in which the count would reach C_TIMEOUT_CYCLES.
// Used only when OPB_MASTER_TIMEOUT_EN is defined.
module opb_master_timeout #(
    parameter int C_TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic suppress,
    output logic expired
);

    localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    // Count enabled, unsuppressed cycles; clear holds it at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && !suppress) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = enable && !suppress && (cnt == CW'(C_TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/opb_master_sequencer.sv
// Single-transaction OPB bus master: takes one command from fabric logic,
// requests the bus, runs one transfer with retry handling and returns a
// response. All outputs come straight from registers; bus outputs are
// zero whenever M_select is low because the OPB buses are OR-combined.
// Optional XFER watchdog: define OPB_MASTER_TIMEOUT_EN.
module opb_master_sequencer
    import opb_master_pkg::*;
#(
    parameter int C_OPB_AWIDTH     = DEF_AWIDTH,
    parameter int C_OPB_DWIDTH     = DEF_DWIDTH,
    parameter int C_MAX_RETRY      = 4,
    parameter int C_TIMEOUT_CYCLES = 16
) (
    input  logic                   OPB_Clk,
    input  logic                   OPB_Rst,
    opb_master_sequencer_if.master bus
);

    localparam int RW = $clog2(C_MAX_RETRY + 1);

    typedef struct packed {
        logic                    cmd_ready;
        logic                    rsp_valid;
        logic [0:C_OPB_DWIDTH-1] rsp_rdata;
        logic                    rsp_err;
        logic                    rsp_timeout;
        logic                    m_request;
        logic                    m_select;
        logic [0:C_OPB_AWIDTH-1] m_abus;
        logic [0:3]              m_be;
        logic [0:C_OPB_DWIDTH-1] m_dbus;
        logic                    m_rnw;
        logic                    rnw;
        logic [0:C_OPB_AWIDTH-1] addr;
        logic [0:C_OPB_DWIDTH-1] wdata;
        logic [0:3]              be;
        logic [RW-1:0]           retry_cnt;
    } regs_t;

    state_t        state_q, state_d;
    regs_t         q, d;
    logic [RW-1:0] retry_inc;
    logic          tmo_expired;

    // Release the bus: deselect and zero every OR-combined bus output.
    function automatic regs_t drop_bus(regs_t r);
        regs_t o;
        o           = r;
        o.m_request = 1'b0;
        o.m_select  = 1'b0;
        o.m_abus    = '0;
        o.m_be      = '0;
        o.m_dbus    = '0;
        o.m_rnw     = 1'b0;
        return o;
    endfunction

`ifdef OPB_MASTER_TIMEOUT_EN
    opb_master_timeout #(
        .C_TIMEOUT_CYCLES(C_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .clear    (state_q != XFER),
        .enable   (state_q == XFER),
        .suppress (bus.OPB_toutSup),
        .expired  (tmo_expired)
    );
`else
    logic unused_tout_sup;
    assign unused_tout_sup = bus.OPB_toutSup;
    assign tmo_expired     = 1'b0;
`endif

    assign retry_inc = q.retry_cnt + 1'b1;

    // Next state and next register image for every output and latched field.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        d       = q;
        unique case (state_q)
            IDLE: begin
                d.cmd_ready = 1'b1;
                if (bus.cmd_valid && q.cmd_ready) begin
                    d.cmd_ready = 1'b0;
                    d.rnw       = bus.cmd_rnw;
                    d.addr      = bus.cmd_addr;
                    d.wdata     = bus.cmd_wdata;
                    d.be        = bus.cmd_be;
                    d.retry_cnt = '0;
                    d.m_request = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (bus.OPB_MGrant) begin
                    d.m_request = 1'b0;
                    d.m_select  = 1'b1;
                    d.m_abus    = q.addr;
                    d.m_be      = q.be;
                    d.m_rnw     = q.rnw;
                    d.m_dbus    = q.rnw ? '0 : q.wdata;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (bus.OPB_xferAck) begin
                    d             = drop_bus(q);
                    d.rsp_valid   = 1'b1;
                    d.rsp_rdata   = q.rnw ? bus.OPB_DBus : '0;
                    d.rsp_err     = bus.OPB_errAck;
                    d.rsp_timeout = 1'b0;
                    state_d       = RSP;
                end else if (bus.OPB_retry) begin
                    d           = drop_bus(q);
                    d.retry_cnt = retry_inc;
                    if (retry_inc == RW'(C_MAX_RETRY)) begin
                        d.rsp_valid   = 1'b1;
                        d.rsp_rdata   = '0;
                        d.rsp_err     = 1'b1;
                        d.rsp_timeout = 1'b0;
                        state_d       = RSP;
                    end else begin
                        d.m_request = 1'b1;
                        state_d     = REQ;
                    end
                end else if (tmo_expired) begin
                    d             = drop_bus(q);
                    d.rsp_valid   = 1'b1;
                    d.rsp_rdata   = '0;
                    d.rsp_err     = 1'b1;
                    d.rsp_timeout = 1'b1;
                    state_d       = RSP;
                end
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    d.rsp_valid   = 1'b0;
                    d.rsp_rdata   = '0;
                    d.rsp_err     = 1'b0;
                    d.rsp_timeout = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge OPB_Clk) begin
        // NOTE: non-blocking assignments so every register samples the pre-edge values.
        if (OPB_Rst) begin
            state_q <= IDLE;
            q       <= '0;
        end else begin
            state_q <= state_d;
            q       <= d;
        end
    end

    assign bus.cmd_ready   = q.cmd_ready;
    assign bus.rsp_valid   = q.rsp_valid;
    assign bus.rsp_rdata   = q.rsp_rdata;
    assign bus.rsp_err     = q.rsp_err;
    assign bus.rsp_timeout = q.rsp_timeout;
    assign bus.M_request   = q.m_request;
    assign bus.M_select    = q.m_select;
    assign bus.M_ABus      = q.m_abus;
    assign bus.M_BE        = q.m_be;
    assign bus.M_DBus      = q.m_dbus;
    assign bus.M_RNW       = q.m_rnw;
    assign bus.M_seqAddr   = 1'b0;

endmodule
